// File: rtl/mem_access_unit.sv
// MEM stage of the 16-bit core: turns EX/MEM load/store control into a
// req/ack data-bus transaction, stalls upstream until done, registers MEM/WB.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_reg_write,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        mem_mem_to_reg,
   input  logic [15:0] mem_alu_result,
   input  logic [15:0] mem_write_data,
   input  logic [2:0]  mem_write_reg,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [15:0] dbus_addr,
   output logic [15:0] dbus_wdata,
   input  logic [15:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        stall_out,
   output logic        bus_err,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [15:0] wb_alu_result,
   output logic [15:0] wb_read_data,
   output logic [2:0]  wb_write_reg
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [15:0]    rbuf;
   logic           acc, ack_hit, tmo, stall_raw;

   // a read+write combination is treated as a plain write
   assign acc = mem_mem_read | mem_mem_write;

   always_comb begin
      state_nxt = state;
      stall_raw = 1'b0;
      ack_hit   = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: if (acc) begin
            stall_raw = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            stall_raw = 1'b1;
            if (dbus_ack) begin
               ack_hit   = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               tmo       = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // stall is forced low while reset is asserted so the pipeline sees no hold
   assign stall_out = stall_raw & rst_n;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_addr     <= '0;
         dbus_wdata    <= '0;
         bus_err       <= 1'b0;
         cnt           <= '0;
         rbuf          <= '0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         wb_alu_result <= '0;
         wb_read_data  <= '0;
         wb_write_reg  <= '0;
      end else begin
         bus_err <= tmo;
         case (state)
            IDLE: begin
               if (acc) begin
                  dbus_addr  <= mem_alu_result;
                  dbus_we    <= mem_mem_write;
                  dbus_wdata <= mem_mem_write ? mem_write_data : 16'h0;
                  dbus_req   <= 1'b1;
                  cnt        <= '0;
               end else begin
                  wb_reg_write  <= mem_reg_write;
                  wb_mem_to_reg <= mem_mem_to_reg;
                  wb_alu_result <= mem_alu_result;
                  wb_write_reg  <= mem_write_reg;
                  wb_read_data  <= 16'h0;
               end
            end
            ACCESS: begin
               if (ack_hit) begin
                  dbus_req <= 1'b0;
                  rbuf     <= dbus_we ? 16'h0 : dbus_rdata;
               end else if (tmo) begin
                  dbus_req <= 1'b0;
                  rbuf     <= 16'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               // EX/MEM is still held by the stall, so its fields are current
               wb_reg_write  <= mem_reg_write;
               wb_mem_to_reg <= mem_mem_to_reg;
               wb_alu_result <= mem_alu_result;
               wb_write_reg  <= mem_write_reg;
               wb_read_data  <= rbuf;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: ALU vector table, bus scoreboard,
// and hand-driven load/store/timeout/reset sequences.
module tb_mem_access_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
   logic [15:0] mem_alu_result, mem_write_data;
   logic [2:0]  mem_write_reg;
   logic        dbus_req, dbus_we;
   logic [15:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic        dbus_ack;
   logic        stall_out, bus_err;
   logic        wb_reg_write, wb_mem_to_reg;
   logic [15:0] wb_alu_result, wb_read_data;
   logic [2:0]  wb_write_reg;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];   // {we, addr, wdata} per expected bus request
   logic        prev_req = 1'b0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
      .mem_write_reg(mem_write_reg),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .stall_out(stall_out), .bus_err(bus_err),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
      .wb_write_reg(wb_write_reg)
   );

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // scoreboard: every new bus request must match the oldest expected one
   always @(negedge clk) begin
      if (dbus_req && !prev_req) begin
         if (exp_q.size() == 0) chk("unexpected_req", {dbus_we, dbus_addr, dbus_wdata}, 33'h1_ffff_ffff);
         else                   chk("bus_txn", {dbus_we, dbus_addr, dbus_wdata}, exp_q.pop_front());
      end
      prev_req <= dbus_req;
   end

   task automatic drive(input logic rw, m2r, rd, wr, input logic [15:0] alu, wd, input logic [2:0] wreg);
      mem_reg_write = rw;  mem_mem_to_reg = m2r;
      mem_mem_read  = rd;  mem_mem_write  = wr;
      mem_alu_result = alu; mem_write_data = wd; mem_write_reg = wreg;
   endtask

   task automatic check_wb(input string nm, input logic rw, m2r, input logic [15:0] alu, rdat, input logic [2:0] wreg);
      chk({nm, ".wb_reg_write"},  wb_reg_write,  rw);
      chk({nm, ".wb_mem_to_reg"}, wb_mem_to_reg, m2r);
      chk({nm, ".wb_alu_result"}, wb_alu_result, alu);
      chk({nm, ".wb_read_data"},  wb_read_data,  rdat);
      chk({nm, ".wb_write_reg"},  wb_write_reg,  wreg);
   endtask

   // Called at posedge+1. Runs one memory instruction to completion,
   // answering the bus after `waits` wait states (or never, if noack).
   task automatic mem_op(input string nm, input logic rd, wr, rw, m2r, input logic [2:0] wreg,
                         input logic [15:0] addr, wd, input int waits, input logic [15:0] rdat,
                         input logic noack, stray, input logic [15:0] exp_rd);
      int stall_cnt = 0, req_cnt = 0, seen = 0;
      logic [15:0] exp_wd = wr ? wd : 16'h0;
      bit done = 0;
      drive(rw, m2r, rd, wr, addr, wd, wreg);
      exp_q.push_back({wr, addr, exp_wd});
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         stall_cnt += int'(stall_out);
         req_cnt   += int'(dbus_req);
         if (!stall_out) begin
            done = 1;
            dbus_ack = stray;
            dbus_rdata = 16'h5A5A;
            chk({nm, ".bus_err"}, bus_err, noack);
            chk({nm, ".req_in_done"}, dbus_req, 1'b0);
         end else if (dbus_req) begin
            chk({nm, ".hold"}, {dbus_we, dbus_addr, dbus_wdata}, {wr, addr, exp_wd});
            if (!noack && seen == waits) begin
               dbus_ack = 1'b1;
               dbus_rdata = rdat;
            end
            seen++;
         end
      end
      if (!done) chk({nm, ".no_completion"}, 33'h0, 33'h1);
      chk({nm, ".req_cycles"},   req_cnt,   noack ? TO : waits + 1);
      chk({nm, ".stall_cycles"}, stall_cnt, noack ? TO + 1 : waits + 2);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      chk({nm, ".bus_err_clear"}, bus_err, 1'b0);
      check_wb(nm, rw, m2r, addr, exp_rd, wreg);
   endtask

   typedef struct {
      logic        rw, m2r;
      logic [15:0] alu;
      logic [2:0]  wreg;
      logic        e_rw, e_m2r;
      logic [15:0] e_alu;
      logic [2:0]  e_wreg;
   } alu_vec_t;

   alu_vec_t tbl[4];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'h1234, 3'd5, 1'b1, 1'b0, 16'h1234, 3'd5};
      tbl[1] = '{1'b0, 1'b0, 16'hFFFF, 3'd7, 1'b0, 1'b0, 16'hFFFF, 3'd7};
      tbl[2] = '{1'b1, 1'b1, 16'h0001, 3'd0, 1'b1, 1'b1, 16'h0001, 3'd0};
      tbl[3] = '{1'b1, 1'b0, 16'hA5A5, 3'd3, 1'b1, 1'b0, 16'hA5A5, 3'd3};

      rst_n = 1'b0; dbus_ack = 1'b0; dbus_rdata = 16'h0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      #1;
      chk("rst.req",   dbus_req,  1'b0);
      chk("rst.stall", stall_out, 1'b0);
      chk("rst.err",   bus_err,   1'b0);
      chk("rst.bus",   {dbus_we, dbus_addr, dbus_wdata}, 33'h0);
      check_wb("rst", 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // non-memory instructions: one-cycle latency, never stall
      for (int i = 0; i < 4; i++) begin
         drive(tbl[i].rw, tbl[i].m2r, 1'b0, 1'b0, tbl[i].alu, 16'hCAFE, tbl[i].wreg);
         @(negedge clk);
         chk($sformatf("alu%0d.stall", i), stall_out, 1'b0);
         chk($sformatf("alu%0d.req", i),   dbus_req,  1'b0);
         @(posedge clk); #1;
         check_wb($sformatf("alu%0d", i), tbl[i].e_rw, tbl[i].e_m2r, tbl[i].e_alu, 16'h0, tbl[i].e_wreg);
      end

      mem_op("load",    1, 0, 1, 1, 3'd2, 16'h0040, 16'h0000, 0, 16'hBEEF, 0, 0, 16'hBEEF);
      mem_op("store",   0, 1, 0, 0, 3'd1, 16'h0010, 16'hA5A5, 3, 16'h0000, 0, 0, 16'h0000);
      mem_op("timeout", 1, 0, 1, 1, 3'd4, 16'h0077, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000);
      mem_op("rdwr",    1, 1, 0, 0, 3'd6, 16'h0020, 16'h1111, 1, 16'hDEAD, 0, 0, 16'h0000);
      // back-to-back loads, stray ack during the first DONE
      mem_op("b2b0",    1, 0, 1, 1, 3'd1, 16'h0001, 16'h0000, 0, 16'h1111, 0, 1, 16'h1111);
      mem_op("b2b1",    1, 0, 1, 1, 3'd3, 16'h0002, 16'h0000, 1, 16'h2222, 0, 0, 16'h2222);

      // stray ack while idle with no access
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      dbus_ack = 1'b1;
      @(negedge clk);
      chk("idle_ack.req",   dbus_req,  1'b0);
      chk("idle_ack.stall", stall_out, 1'b0);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack.err", bus_err, 1'b0);
      chk("idle_ack.req2", dbus_req, 1'b0);
      @(posedge clk); #1;

      // leave non-zero wb state, then reset mid-ACCESS
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0, 3'd7);
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0, 3'd5);
      exp_q.push_back({1'b0, 16'h0300, 16'h0000});
      @(negedge clk);
      @(negedge clk);
      chk("rstmid.req_before", dbus_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid.req",   dbus_req,  1'b0);
      chk("rstmid.stall", stall_out, 1'b0);
      chk("rstmid.err",   bus_err,   1'b0);
      check_wb("rstmid", 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      dbus_ack = 1'b1; dbus_rdata = 16'h9999;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_ack.req",   dbus_req,  1'b0);
      chk("post_rst_ack.stall", stall_out, 1'b0);
      chk("post_rst_ack.err",   bus_err,   1'b0);
      chk("post_rst_ack.wbrd",  wb_read_data, 16'h0);
      dbus_ack = 1'b0;
      @(posedge clk); #1;
      mem_op("after_rst", 1, 0, 1, 1, 3'd2, 16'h0050, 16'h0000, 2, 16'h4321, 0, 0, 16'h4321);

      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
